// File: rtl/zoom_pkg.sv
// rtl/zoom_pkg.sv - shared types and constants for the zoom line read scheduler
//
// Contents:
//   state_t        scheduler FSM state encoding
//   DEF_*          default widths (pixel, line counter, phase fraction)
//   PHASE_ONE      1.0 in phase-accumulator units for the default PHASE_W
//   phase_one()    1.0 in phase-accumulator units for an arbitrary PHASE_W
package zoom_pkg;

    localparam int DEF_DATA_W  = 24;
    localparam int DEF_LINE_W  = 12;
    localparam int DEF_PHASE_W = 16;

    localparam int PHASE_ONE = 1 << DEF_PHASE_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    function automatic int phase_one(input int phase_w);
        return 1 << phase_w;
    endfunction

endpackage

// File: rtl/zoom_hdmi_rd_sched_if.sv
// rtl/zoom_hdmi_rd_sched_if.sv - FWFT FIFO read-port bundle between FIFO and scheduler
//
// Signals:
//   fifo_rd_en    pop request from the scheduler
//   fifo_rd_vld   FIFO head is valid; a pop happens on fifo_rd_en & fifo_rd_vld
//   fifo_rd_data  FIFO head data (first-word-fall-through)
// Modports:
//   master  scheduler side (drives fifo_rd_en)
//   slave   FIFO side (drives fifo_rd_vld / fifo_rd_data)
interface zoom_hdmi_rd_sched_if
    import zoom_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              fifo_rd_en;
    logic              fifo_rd_vld;
    logic [DATA_W-1:0] fifo_rd_data;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_vld,
        input  fifo_rd_data
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_vld,
        output fifo_rd_data
    );

endinterface

// File: rtl/zoom_phase_acc.sv
// rtl/zoom_phase_acc.sv - fractional phase accumulator for nearest-neighbour upscaling
//
// Ports:
//   rd_clk, rd_rst  clock, asynchronous active-high reset
//   clr             zero the accumulator (start of line)
//   advance         one output pixel is being produced this cycle
//   step            phase increment, PHASE_W fractional bits plus the integer bit
//   carry           the phase crossed an integer boundary this cycle:
//                   the next output pixel needs the next source pixel
module zoom_phase_acc
    import zoom_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             clr,
    input  logic             advance,
    input  logic [PHASE_W:0] step,
    output logic             carry
);

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W:0]   sum;

    // step never exceeds 1.0, so one extra bit holds the whole sum and at
    // most one source pixel is consumed per output pixel.
    assign sum   = {1'b0, acc} + step;
    assign carry = advance & sum[PHASE_W];

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (advance) begin
            acc <= sum[PHASE_W-1:0];
        end
    end

endmodule

// File: rtl/zoom_hdmi_rd_sched.sv
// rtl/zoom_hdmi_rd_sched.sv - HDMI-side read scheduler for the zoom line FIFO
//
// Ports:
//   rd_clk, rd_rst                  FIFO read clock, asynchronous active-high reset
//   cfg_src_width / cfg_out_width   source / output pixels per line (latched at line_start)
//   cfg_step                        phase increment, 2^PHASE_W * src / out
//   line_start                      one-cycle pulse at the start of each active line
//   de_req                          one output pixel requested per asserted cycle
//   fifo                            FWFT FIFO read port (master side)
//   pix_data, pix_vld               registered output pixel, one cycle after de_req
//   line_done                       one-cycle pulse when the line is retired
//   err_clr                         clears the sticky flags
//   underflow                       sticky: a needed pop found the FIFO empty, or
//                                   de_req arrived outside an active line
//   line_err                        sticky: line_start arrived while a line was in flight
module zoom_hdmi_rd_sched
    import zoom_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic [LINE_W-1:0]   cfg_src_width,
    input  logic [LINE_W-1:0]   cfg_out_width,
    input  logic [PHASE_W:0]    cfg_step,
    input  logic                line_start,
    input  logic                de_req,
    zoom_hdmi_rd_sched_if.master fifo,
    output logic [DATA_W-1:0]   pix_data,
    output logic                pix_vld,
    output logic                line_done,
    input  logic                err_clr,
    output logic                underflow,
    output logic                line_err
);

    state_t              state;
    state_t              state_nxt;

    logic [LINE_W-1:0]   src_w;
    logic [LINE_W-1:0]   out_w;
    logic [PHASE_W:0]    step_r;
    logic [LINE_W-1:0]   src_cnt;
    logic [LINE_W-1:0]   out_cnt;
    logic [DATA_W-1:0]   hold;

    logic                rd_en;
    logic                pop;
    logic                advance;
    logic                carry;
    logic                src_more;
    logic                acc_clr;
    logic                uf_evt;
    logic                le_evt;

    assign advance  = (state == ST_ACTIVE) && de_req;
    assign src_more = (src_cnt < src_w);
    assign acc_clr  = (state == ST_IDLE) && line_start;
    assign pop      = rd_en && fifo.fifo_rd_vld;

    assign fifo.fifo_rd_en = rd_en;

    zoom_phase_acc #(
        .PHASE_W (PHASE_W)
    ) u_phase_acc (
        .rd_clk  (rd_clk),
        .rd_rst  (rd_rst),
        .clr     (acc_clr),
        .advance (advance),
        .step    (step_r),
        .carry   (carry)
    );

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // rd_en is derived only from state and our own counters so it never
    // forms a combinational loop with the FIFO's valid logic.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (line_start) begin
                    state_nxt = ST_PRIME;
                end
            end
            ST_PRIME: begin
                rd_en = 1'b1;
                if (fifo.fifo_rd_vld) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (de_req) begin
                    // Once the whole source line is consumed the carry is
                    // clamped and the last source pixel simply repeats.
                    rd_en = carry && src_more;
                    if ((out_cnt + LINE_W'(1)) == out_w) begin
                        state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // Drain whatever the line did not consume so the next
                // line_start finds that line's first pixel at the FIFO head.
                if (src_more) begin
                    rd_en = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // A missed pop is not retried: hold keeps its pixel and src_cnt does not
    // advance, so FLUSH later drains the pixel that was skipped.
    assign uf_evt = (advance && carry && src_more && !fifo.fifo_rd_vld) ||
                    (de_req && (state != ST_ACTIVE));
    assign le_evt = line_start && (state != ST_IDLE);

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            src_w     <= '0;
            out_w     <= '0;
            step_r    <= '0;
            src_cnt   <= '0;
            out_cnt   <= '0;
            hold      <= '0;
            pix_data  <= '0;
            pix_vld   <= 1'b0;
            line_done <= 1'b0;
            underflow <= 1'b0;
            line_err  <= 1'b0;
        end else begin
            pix_vld   <= advance;
            line_done <= (state == ST_FLUSH) && !src_more;
            // A new error in the same cycle as err_clr keeps the flag set.
            underflow <= uf_evt || (underflow && !err_clr);
            line_err  <= le_evt || (line_err && !err_clr);

            if (advance) begin
                pix_data <= hold;
            end

            case (state)
                ST_IDLE: begin
                    if (line_start) begin
                        src_w   <= cfg_src_width;
                        out_w   <= cfg_out_width;
                        step_r  <= cfg_step;
                        src_cnt <= '0;
                        out_cnt <= '0;
                    end
                end
                ST_PRIME: begin
                    if (pop) begin
                        hold    <= fifo.fifo_rd_data;
                        src_cnt <= LINE_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (advance) begin
                        out_cnt <= out_cnt + LINE_W'(1);
                    end
                    if (pop) begin
                        hold    <= fifo.fifo_rd_data;
                        src_cnt <= src_cnt + LINE_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (pop) begin
                        src_cnt <= src_cnt + LINE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zoom_hdmi_rd_sched.sv
// tb/tb_zoom_hdmi_rd_sched.sv - self-checking bench for zoom_hdmi_rd_sched
module tb_zoom_hdmi_rd_sched;
    import zoom_pkg::*;

    localparam int DATA_W  = 24;
    localparam int LINE_W  = 12;
    localparam int PHASE_W = 16;

    typedef struct packed {
        logic [11:0]      src;
        logic [11:0]      outw;
        logic [16:0]      step;
        logic [15:0][3:0] exp_idx;
        logic [7:0]       exp_pops;
        logic             exp_uf;
        logic             exp_le;
        logic             gap;
        logic             mid_ls;
        logic             gate_en;
        logic [3:0]       gate_lo;
        logic [3:0]       gate_hi;
        logic [3:0]       exp_lat;
    } vec_t;

    logic                rd_clk;
    logic                rd_rst;
    logic [LINE_W-1:0]   cfg_src_width;
    logic [LINE_W-1:0]   cfg_out_width;
    logic [PHASE_W:0]    cfg_step;
    logic                line_start;
    logic                de_req;
    logic [DATA_W-1:0]   pix_data;
    logic                pix_vld;
    logic                line_done;
    logic                err_clr;
    logic                underflow;
    logic                line_err;

    zoom_hdmi_rd_sched_if #(.DATA_W(DATA_W)) fifo_if ();

    zoom_hdmi_rd_sched #(
        .DATA_W  (DATA_W),
        .LINE_W  (LINE_W),
        .PHASE_W (PHASE_W)
    ) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .cfg_src_width (cfg_src_width),
        .cfg_out_width (cfg_out_width),
        .cfg_step      (cfg_step),
        .line_start    (line_start),
        .de_req        (de_req),
        .fifo          (fifo_if),
        .pix_data      (pix_data),
        .pix_vld       (pix_vld),
        .line_done     (line_done),
        .err_clr       (err_clr),
        .underflow     (underflow),
        .line_err      (line_err)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] got[$];
    logic              gate;
    int                pops;
    int                done_cnt;
    int                n_cmp;
    int                n_fail;
    vec_t              vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FWFT FIFO model: head is visible whenever the queue holds data and
    // the bench is not forcing an empty condition.
    task automatic refresh();
        fifo_if.fifo_rd_vld  = (q.size() > 0) && !gate;
        fifo_if.fifo_rd_data = (q.size() > 0) ? q[0] : '0;
    endtask

    task automatic cycle();
        logic p;
        @(negedge rd_clk);
        p = fifo_if.fifo_rd_en && fifo_if.fifo_rd_vld;
        if (pix_vld) got.push_back(pix_data);
        if (line_done) done_cnt++;
        @(posedge rd_clk);
        #1;
        if (p) begin
            void'(q.pop_front());
            pops++;
        end
        refresh();
    endtask

    function automatic vec_t mk(input int src, input int outw, input int step,
                                input logic [63:0] idx, input int npops,
                                input bit uf, input bit le, input bit gp, input bit mid,
                                input bit gen, input int lo, input int hi, input int lat);
        vec_t v;
        v.src      = 12'(src);
        v.outw     = 12'(outw);
        v.step     = 17'(step);
        v.exp_idx  = idx;
        v.exp_pops = 8'(npops);
        v.exp_uf   = uf;
        v.exp_le   = le;
        v.gap      = gp;
        v.mid_ls   = mid;
        v.gate_en  = gen;
        v.gate_lo  = 4'(lo);
        v.gate_hi  = 4'(hi);
        v.exp_lat  = 4'(lat);
        return v;
    endfunction

    task automatic start_line(input vec_t v, input int tag);
        for (int i = 0; i < int'(v.src); i++) q.push_back({8'(tag), 16'(i)});
        got.delete();
        pops          = 0;
        done_cnt      = 0;
        cfg_src_width = v.src;
        cfg_out_width = v.outw;
        cfg_step      = v.step;
        line_start    = 1'b1;
        refresh();
        cycle();
        line_start = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic run_line(input vec_t v, input int tag);
        int w;
        logic [31:0] act;
        start_line(v, tag);
        for (int k = 0; k < int'(v.outw); k++) begin
            if (v.gap && k > 0) begin
                de_req     = 1'b0;
                line_start = 1'b0;
                cycle();
            end
            de_req     = 1'b1;
            line_start = v.mid_ls && (k == 2);
            gate       = v.gate_en && (k >= int'(v.gate_lo)) && (k <= int'(v.gate_hi));
            refresh();
            cycle();
        end
        de_req     = 1'b0;
        line_start = 1'b0;
        gate       = 1'b0;
        refresh();
        w = 0;
        while (done_cnt == 0 && w < 20) begin
            cycle();
            w++;
        end
        repeat (2) cycle();
        chk($sformatf("t%0d line_done_lat", tag), w, 32'(v.exp_lat));
        chk($sformatf("t%0d line_done_cnt", tag), done_cnt, 1);
        chk($sformatf("t%0d pix_count", tag), got.size(), 32'(v.outw));
        for (int i = 0; i < int'(v.outw); i++) begin
            act = (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF;
            chk($sformatf("t%0d pix%0d", tag, i), act, {8'h00, 8'(tag), 12'h000, v.exp_idx[i]});
        end
        chk($sformatf("t%0d pops", tag), pops, 32'(v.exp_pops));
        chk($sformatf("t%0d fifo_left", tag), q.size(), 0);
        chk($sformatf("t%0d underflow", tag), underflow, v.exp_uf);
        chk($sformatf("t%0d line_err", tag), line_err, v.exp_le);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk($sformatf("t%0d uf_cleared", tag), underflow, 0);
        chk($sformatf("t%0d le_cleared", tag), line_err, 0);
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        pops          = 0;
        done_cnt      = 0;
        gate          = 1'b0;
        rd_rst        = 1'b1;
        cfg_src_width = '0;
        cfg_out_width = '0;
        cfg_step      = '0;
        line_start    = 1'b0;
        de_req        = 1'b0;
        err_clr       = 1'b0;
        refresh();

        // step 0x8000 = 0.5: each source pixel twice
        vecs[0] = mk(4, 8, 32'h8000, 64'h3322_1100, 4, 0, 0, 0, 0, 0, 0, 0, 2);
        // step 1.0: one-to-one, last carry clamped
        vecs[1] = mk(5, 5, 32'h10000, 64'h4_3210, 5, 0, 0, 0, 0, 0, 0, 0, 2);
        // step ~1/3: each source pixel three times
        vecs[2] = mk(3, 9, 32'h5556, 64'h2_2211_1000, 3, 0, 0, 0, 0, 0, 0, 0, 2);
        // FIFO empty across requests 3..5: s2 pop missed twice, s1 repeats, s3 drained
        vecs[3] = mk(4, 8, 32'h8000, 64'h1111_1100, 4, 1, 0, 0, 0, 1, 3, 5, 3);
        // gapped de_req with a stray line_start mid-line
        vecs[4] = mk(4, 8, 32'h8000, 64'h3322_1100, 4, 0, 1, 1, 1, 0, 0, 0, 2);

        repeat (2) cycle();
        chk("rst fifo_rd_en", fifo_if.fifo_rd_en, 0);
        chk("rst pix_data", pix_data, 0);
        chk("rst pix_vld", pix_vld, 0);
        chk("rst line_done", line_done, 0);
        chk("rst underflow", underflow, 0);
        chk("rst line_err", line_err, 0);
        rd_rst = 1'b0;
        cycle();

        // de_req while IDLE: ignored but flagged
        de_req = 1'b1;
        cycle();
        chk("idle_req pix_vld", pix_vld, 0);
        chk("idle_req underflow", underflow, 1);
        // err_clr together with a new error: error wins
        err_clr = 1'b1;
        cycle();
        chk("clr_vs_err underflow", underflow, 1);
        de_req = 1'b0;
        cycle();
        err_clr = 1'b0;
        chk("clr underflow", underflow, 0);

        for (int i = 0; i < 5; i++) run_line(vecs[i], i + 1);

        // reset in the middle of an active line
        start_line(vecs[0], 9);
        de_req = 1'b1;
        repeat (3) cycle();
        rd_rst = 1'b1;
        #1;
        chk("midrst fifo_rd_en", fifo_if.fifo_rd_en, 0);
        chk("midrst pix_data", pix_data, 0);
        chk("midrst pix_vld", pix_vld, 0);
        chk("midrst line_done", line_done, 0);
        chk("midrst underflow", underflow, 0);
        chk("midrst line_err", line_err, 0);
        de_req = 1'b0;
        q.delete();
        refresh();
        repeat (2) cycle();
        rd_rst = 1'b0;
        cycle();
        run_line(vecs[0], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/zoom_hdmi_rd_sched.md
# zoom_hdmi_rd_sched

Read-side scheduler for the 24-bit zoom line FIFO feeding the HDMI output. Pops source pixels from the first-word-fall-through prefetch FIFO (rd_en/rd_vld/rd_data) under control of an HDMI pixel-request strobe. Performs nearest-neighbour horizontal upscaling with a fixed-point phase accumulator. Keeps the FIFO line-aligned by draining unused source pixels at end of line.

## Interface

Parameters:
- DATA_W, 24, pixel width
- LINE_W, 12, width of pixel counters and width configs
- PHASE_W, 16, fractional bits of phase step; 1.0 = 2^PHASE_W

Ports:
- Clock `rd_clk`, in, 1: shared with the FIFO read side.
- Reset `rd_rst`, in, 1: asynchronous, active-high.
- cfg_src_width, in, LINE_W: source pixels per line, legal 1..2^LINE_W-1.
- cfg_out_width, in, LINE_W: output pixels per line, legal ≥ cfg_src_width.
- cfg_step, in, PHASE_W+1: phase increment = 2^PHASE_W·src/out, legal 1..2^PHASE_W.
- line_start, in, 1: one-cycle pulse at start of each active line.
- de_req, in, 1: output pixel request, one pixel per asserted cycle.
- fifo_rd_data, in, DATA_W: FIFO head data.
- fifo_rd_vld, in, 1: FIFO head valid.
- fifo_rd_en, out, 1: pop request. A pop occurs when fifo_rd_en & fifo_rd_vld.
- pix_data, out, DATA_W: output pixel.
- pix_vld, out, 1: pix_data valid.
- line_done, out, 1: one-cycle pulse when a line is fully retired.
- err_clr, in, 1: clears the sticky error flags.
- underflow, out, 1: sticky; a required pop found FIFO empty.
- line_err, out, 1: sticky; line_start arrived while not IDLE.

## Operation

- States:
  - IDLE, PRIME, ACTIVE, FLUSH.
- IDLE:
  - line_start latches the cfg_* inputs.
  - Clears acc, out_cnt and src_cnt, then moves to PRIME.
- PRIME:
  - Holds fifo_rd_en=1.
  - On the pop: hold <= fifo_rd_data, src_cnt=1, then moves to ACTIVE.
- ACTIVE:
  - Each de_req cycle outputs hold and increments out_cnt.
  - Computes sum = acc + step (PHASE_W+1 bits); acc <= sum[PHASE_W-1:0]; carry = sum[PHASE_W].
  - carry & src_cnt<src_width: fifo_rd_en=1 in the same cycle.
    - If fifo_rd_vld: hold <= fifo_rd_data and src_cnt++.
    - Otherwise: underflow set, hold kept, no retry.
  - carry & src_cnt==src_width: pop is clamped, hold repeats.
  - When de_req is low: no acc update, no pop.
  - When out_cnt reaches out_width: move to FLUSH.
- FLUSH:
  - fifo_rd_en=1 while src_cnt<src_width; each pop increments src_cnt.
  - When src_cnt==src_width: line_done pulse, then IDLE.
- de_req outside ACTIVE: ignored; pix_vld stays 0 and underflow is set.
- line_start outside IDLE: ignored and line_err set. The current line completes.
- err_clr: clears the sticky flags on the next edge. A simultaneous new error event wins (flag stays set).

## Timing

- Reset values: fifo_rd_en=0, pix_data=0, pix_vld=0, line_done=0, underflow=0, line_err=0. State=IDLE, acc=0.
- fifo_rd_en is combinational from state, carry and fifo-independent counters. It does not depend on fifo_rd_vld.
- pix_vld/pix_data are registered: pix_vld = de_req delayed 1 cycle; pix_data = hold as sampled at the de_req edge. A same-edge pop affects only the next pixel.
- PRIME→ACTIVE latency is 2 cycles after line_start when the FIFO is non-empty. de_req must not lead line_start by fewer than 3 cycles.
- line_done is asserted 1 cycle after the last FLUSH pop. If no drain is needed, it is asserted 1 cycle after the final output pixel.
- Reset mid-line returns to IDLE immediately. FIFO realignment is the system's responsibility (reset both sides together).

## Structure

- Shared package zoom_pkg: state enum; PHASE_ONE = 1<<PHASE_W; default widths.
- Sub-module zoom_phase_acc: holds acc, and outputs carry from step and advance.
- The top level holds the FSM, the counters, hold and the output registers.

## Test plan

- src=4, out=8, step=0x8000, FIFO preloaded s0..s3, de_req held 8 cycles → pix_data s0,s0,s1,s1,s2,s2,s3,s3; exactly 4 pops; line_done once; no errors.
- src=out=5, step=0x10000 → pixels s0..s4 one-to-one; 5 pops; last carry clamped; FIFO empty after line.
- src=3, out=9, step=0x5556 → s0×3, s1×3, s2×3.
- FIFO empty at a required pop (withhold s2 in case 1) → underflow=1; s1 repeated; FLUSH drains remaining so next line starts at the next line's s0; err_clr clears underflow.
- line_start during ACTIVE → line_err=1, output sequence unchanged; de_req gapped every other cycle → same pixel sequence, stretched.
- rd_rst asserted mid-ACTIVE → all outputs 0 at once; next line_start after FIFO reset runs case 1 correctly.
